// File: rtl/muldiv_pkg.sv
// Shared encodings, state enum, latencies and sign decode for the RV32M multiply/divide controller.
package muldiv_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned DIV_ITERS = 32;
    localparam int unsigned CNT_W     = 6;
    localparam int unsigned MUL_LAT   = 2;
    localparam int unsigned DIV_LAT   = 34;

    localparam logic [2:0] MD_MUL    = 3'b000;
    localparam logic [2:0] MD_MULH   = 3'b001;
    localparam logic [2:0] MD_MULHSU = 3'b010;
    localparam logic [2:0] MD_MULHU  = 3'b011;
    localparam logic [2:0] MD_DIV    = 3'b100;
    localparam logic [2:0] MD_DIVU   = 3'b101;
    localparam logic [2:0] MD_REM    = 3'b110;
    localparam logic [2:0] MD_REMU   = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_FIX,
        ST_DONE
    } state_e;

    typedef struct packed {
        logic a_sgn;
        logic b_sgn;
    } sign_t;

    // Whether rs1 / rs2 are treated as signed for the given op.
    function automatic sign_t sign_decode(input logic [2:0] f3);
        sign_t s;
        case (f3)
            MD_MUL, MD_MULH, MD_DIV, MD_REM: s = '{a_sgn: 1'b1, b_sgn: 1'b1};
            MD_MULHSU:                       s = '{a_sgn: 1'b1, b_sgn: 1'b0};
            default:                         s = '{a_sgn: 1'b0, b_sgn: 1'b0};
        endcase
        return s;
    endfunction

    function automatic logic is_div(input logic [2:0] f3);
        return f3[2];
    endfunction

endpackage

// File: rtl/muldiv_div_step.sv
// One combinational restoring-division iteration: shift remainder, trial subtract, emit quotient bit.
module div_step
    import muldiv_pkg::*;
(
    input  logic [XLEN-1:0] rem_i,
    input  logic [XLEN-1:0] quo_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN-1:0] rem_o,
    output logic [XLEN-1:0] quo_o
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] trial;

    // Borrow out of the 33-bit trial subtract means the divisor did not fit.
    always_comb begin
        shifted = {rem_i, quo_i[XLEN-1]};
        trial   = shifted - {1'b0, divisor_i};
        rem_o   = trial[XLEN] ? shifted[XLEN-1:0] : trial[XLEN-1:0];
        quo_o   = {quo_i[XLEN-2:0], ~trial[XLEN]};
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// RV32M multi-cycle multiply/divide controller with pipeline stall and flush handling.
// Build option MULDIV_DIV_EARLY_OUT_EN: divide-by-zero and signed overflow finish in one cycle.
module muldiv_ctrl
    import muldiv_pkg::*;
(
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            start_i,
    input  logic            kill_i,
    input  logic [2:0]      func3_i,
    input  logic [XLEN-1:0] opa_i,
    input  logic [XLEN-1:0] opb_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o,
    output logic            stall_o
);

    state_e              state_q;
    logic [2:0]          op_q;
    logic [XLEN-1:0]     a_q, b_q, rem_q, quo_q, dvs_q, res_q, result_q;
    logic [2*XLEN-1:0]   prod_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                ph_q, busy_q, done_q;

    sign_t               sgn_in, sgn_op;
    logic [XLEN-1:0]     abs_a_d, abs_b_d, rem_d, quo_d, quo_fix, rem_fix, fix_d;
    logic [2*XLEN-1:0]   a_w, b_w, prod_d;
    logic                a_neg, b_neg, b_zero;

    div_step u_div_step (
        .rem_i     (rem_q),
        .quo_i     (quo_q),
        .divisor_i (dvs_q),
        .rem_o     (rem_d),
        .quo_o     (quo_d)
    );

    // Operand magnitudes, product, and sign correction of the raw divider outputs.
    always_comb begin
        sgn_in  = sign_decode(func3_i);
        sgn_op  = sign_decode(op_q);
        abs_a_d = (sgn_in.a_sgn && opa_i[XLEN-1]) ? -opa_i : opa_i;
        abs_b_d = (sgn_in.b_sgn && opb_i[XLEN-1]) ? -opb_i : opb_i;
        // Low 64 bits of the 33x33 signed/unsigned product need only sign-extended operands.
        a_w     = {{XLEN{sgn_op.a_sgn & a_q[XLEN-1]}}, a_q};
        b_w     = {{XLEN{sgn_op.b_sgn & b_q[XLEN-1]}}, b_q};
        prod_d  = a_w * b_w;
        a_neg   = sgn_op.a_sgn & a_q[XLEN-1];
        b_neg   = sgn_op.b_sgn & b_q[XLEN-1];
        b_zero  = (b_q == '0);
        // Divide-by-zero keeps the all-ones quotient whatever the dividend sign.
        quo_fix = ((a_neg ^ b_neg) && !b_zero) ? -quo_q : quo_q;
        rem_fix = a_neg ? -rem_q : rem_q;
        fix_d   = op_q[1] ? rem_fix : quo_fix;
    end

`ifdef MULDIV_DIV_EARLY_OUT_EN
    logic            div_zero_d, div_ovf_d;
    logic [XLEN-1:0] corner_d;

    always_comb begin
        div_zero_d = (opb_i == '0);
        div_ovf_d  = sgn_in.a_sgn && (opa_i == {1'b1, {(XLEN-1){1'b0}}}) && (opb_i == '1);
        if (func3_i[1]) begin
            corner_d = div_zero_d ? opa_i : '0;
        end else begin
            corner_d = div_zero_d ? '1 : {1'b1, {(XLEN-1){1'b0}}};
        end
    end
`endif

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= ST_IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            res_q    <= '0;
            result_q <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
            ph_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else if (kill_i) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start_i) begin
                        op_q   <= func3_i;
                        a_q    <= opa_i;
                        b_q    <= opb_i;
                        busy_q <= 1'b1;
                        ph_q   <= 1'b0;
                        cnt_q  <= '0;
                        rem_q  <= '0;
                        quo_q  <= abs_a_d;
                        dvs_q  <= abs_b_d;
                        if (!is_div(func3_i)) begin
                            state_q <= ST_MUL;
                        end else begin
`ifdef MULDIV_DIV_EARLY_OUT_EN
                            if (div_zero_d || div_ovf_d) begin
                                res_q   <= corner_d;
                                ph_q    <= 1'b1;
                                state_q <= ST_FIX;
                            end else begin
                                state_q <= ST_DIV;
                            end
`else
                            state_q <= ST_DIV;
`endif
                        end
                    end else begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                ST_MUL: begin
                    if (!ph_q) begin
                        prod_q <= prod_d;
                        ph_q   <= 1'b1;
                    end else begin
                        result_q <= (op_q == MD_MUL) ? prod_q[XLEN-1:0] : prod_q[2*XLEN-1:XLEN];
                        state_q  <= ST_DONE;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                    end
                end
                ST_DIV: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(DIV_ITERS - 1)) begin
                        state_q <= ST_FIX;
                        ph_q    <= 1'b0;
                    end
                end
                ST_FIX: begin
                    if (!ph_q) begin
                        res_q <= fix_d;
                        ph_q  <= 1'b1;
                    end else begin
                        result_q <= res_q;
                        state_q  <= ST_DONE;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign result_o = result_q;
    assign stall_o  = (start_i && (state_q == ST_IDLE) && !kill_i) || busy_q;

endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Multi-cycle controller for the RV32M multiply/divide operations in the execute stage. It runs beside the single-cycle ALU. It accepts one M-extension operation per START, sequences a registered multiplier or a 32-iteration restoring divider, and holds the pipeline via STALL until the result is valid. It also handles the RISC-V corner cases (divide-by-zero, signed overflow) and lets the pipeline kill an in-flight operation on a flush.

## Interface
- XLEN, 32, operand/result width; only 32 is supported.
- DIV_ITERS, 32, number of divider iterations; must equal XLEN.
- CLK  input  1  rising-edge clock; single clock domain.
- RESET  input  1  synchronous, active-high reset.
- START  input  1  request; M-ext instruction present in EX with valid operands.
- KILL  input  1  pipeline flush; aborts any in-flight or same-cycle request.
- FUNC3  input  3  M-ext op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- OPA  input  32  rs1 value.
- OPB  input  32  rs2 value.
- BUSY  output  1  operation in flight.
- DONE  output  1  one-cycle pulse; RESULT valid this cycle.
- RESULT  output  32  rd value; held until the next accepted START.
- STALL  output  1  combinational: (START & state==IDLE & ~KILL) | BUSY.

## Operation
- States: IDLE, MUL, DIV, FIX, DONE.
- Acceptance:
  - START is accepted only in IDLE or DONE with KILL low.
  - The accepting edge latches FUNC3, OPA and OPB.
  - START is ignored in MUL, DIV and FIX; the pipeline is already stalled.
- MUL path:
  - Operands are extended to 33 bits (signed or unsigned per op) and the 66-bit product is registered in MUL.
  - MUL returns product[31:0]; MULH, MULHSU and MULHU return product[63:32].
- DIV path:
  - Absolute values are taken for signed ops, then DIV runs DIV_ITERS restoring steps. Each step is a shift-left of the remainder, a trial subtract, and a quotient bit.
  - An iteration counter (6 bits) counts 0..31. DIV→FIX happens when the counter is 31.
  - FIX negates the quotient when the operand signs differ (DIV). It gives the remainder the sign of the dividend (REM).
- Corner cases (results are architectural regardless of configuration):
  - Divide by zero: quotient 0xFFFFFFFF and remainder = OPA, for both signed and unsigned ops.
  - Signed overflow (OPA=0x80000000, OPB=0xFFFFFFFF, DIV/REM): quotient 0x80000000, remainder 0.
- DONE state:
  - DONE=1 and RESULT is driven from the result register.
  - Next state is MUL or DIV if a new START is accepted, otherwise IDLE.
- KILL:
  - In any state, the next state is IDLE. No DONE is issued and RESULT is unchanged.
  - KILL together with START in IDLE: KILL wins and the request is dropped.
- Reset value of every output is 0 (RESULT=0, BUSY=0, DONE=0; STALL=0 absent START). State resets to IDLE, and reset mid-operation discards the operation.

## Timing
- The request is accepted at edge E0.
- DONE is high in the cycle after:
  - E2 for MUL* (MUL→DONE).
  - E34 for DIV/REM (E1..E32 iterate, E33 FIX, E34 enter DONE).
- BUSY is high from after E0 until DONE; it is 0 in the DONE cycle. STALL therefore drops in the DONE cycle and EX advances on the DONE edge.
- A back-to-back START in the DONE cycle is accepted at that edge, giving zero bubble.
- OPA and OPB may change after E0 without effect.

## Configuration
- MULDIV_DIV_EARLY_OUT_EN:
  - Defined: divide-by-zero and signed overflow are detected at E0 and go straight to DONE, so DONE is high after E1 (latency 1).
  - Undefined: these cases run the full DIV/FIX sequence (latency 34). The restoring algorithm plus the FIX rules must produce identical results.
- RESULT values are identical in both builds.

## Structure
- muldiv_pkg holds:
  - The FUNC3 encodings as localparams (MD_MUL … MD_REMU).
  - The state enum.
  - The latency constants MUL_LAT=2 and DIV_LAT=34.
  - A helper function for the signed/unsigned decode of FUNC3.
- Sub-module div_step: a combinational single restoring iteration, taking {rem_in, quo_in, divisor} and producing {rem_out, quo_out}. It is instantiated once and reused each DIV cycle.

## Test plan
- MULH, OPA=0x80000000, OPB=0x80000000: DONE after E2, RESULT=0x40000000. MULHU, OPA=0xFFFFFFFF, OPB=0xFFFFFFFF: RESULT=0xFFFFFFFE.
- DIV, OPA=-7 (0xFFFFFFF9), OPB=2: RESULT=0xFFFFFFFD after E34. REM on the same operands: RESULT=0xFFFFFFFF. STALL is high in cycles E0..E33.
- DIVU, OPB=0: RESULT=0xFFFFFFFF. REM, OPA=0x80000000, OPB=0xFFFFFFFF: RESULT=0. Latency is 1 with MULDIV_DIV_EARLY_OUT_EN and 34 without.
- KILL at E10 of a DIV: the next state is IDLE, no DONE pulse, RESULT unchanged. START+KILL together in IDLE: no acceptance, STALL=0.
- Back-to-back: MUL 3×5, then START DIVU 100/7 in the DONE cycle. Expect RESULT 15, then 14, with no idle cycle between operations.
- RESET asserted during DIV at E20: all outputs 0 on the next cycle, state IDLE, and a fresh START is accepted normally.
